// File: rtl/weight_bram_controller_pkg.sv
// Shared constants and FSM encoding for the weight BRAM read-address sequencer.
package weight_bram_controller_pkg;

  localparam int NUM_BANKS = 16;
  localparam int ADDR_W    = 9;
  localparam int DRAIN_W   = $clog2(NUM_BANKS);

  // Drain counter value on the last of the NUM_BANKS-1 drain cycles
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(NUM_BANKS - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/weight_bram_controller_skew_delay_line.sv
// Shift register of {enable, address} pairs producing the skewed lanes 1..NUM_BANKS-1.
// Output tap j carries lane 0 delayed by j+1 cycles.
module weight_bram_controller_skew_delay_line
  import weight_bram_controller_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en_in,
  input  logic [ADDR_W-1:0]               addr_in,
  output logic [NUM_BANKS-2:0]            en_taps,
  output logic [(NUM_BANKS-1)*ADDR_W-1:0] addr_taps
);

  logic [NUM_BANKS-2:0] en_r;
  logic [ADDR_W-1:0]    addr_r [NUM_BANKS-1];

  // Advance every stage by one lane per cycle; reset empties the whole line
  always_ff @(posedge clk) begin
    if (rst) begin
      en_r <= '0;
      for (int j = 0; j < NUM_BANKS - 1; j++) begin
        addr_r[j] <= '0;
      end
    end else begin
      en_r      <= {en_r[NUM_BANKS-3:0], en_in};
      addr_r[0] <= addr_in;
      for (int j = 1; j < NUM_BANKS - 1; j++) begin
        addr_r[j] <= addr_r[j-1];
      end
    end
  end

  // Flatten the stage addresses into the tap bus
  always_comb begin
    addr_taps = '0;
    for (int j = 0; j < NUM_BANKS - 1; j++) begin
      addr_taps[j*ADDR_W +: ADDR_W] = addr_r[j];
    end
  end

  assign en_taps = en_r;

endmodule

// File: rtl/weight_bram_controller.sv
// Read-address sequencer for the weight BRAM banks. Lane 0 sweeps addr_start..addr_end,
// every further lane repeats lane 0 one cycle later, and done pulses once the last lane
// has issued its last address.
module weight_bram_controller
  import weight_bram_controller_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           addr_start,
  input  logic [ADDR_W-1:0]           addr_end,
  output logic [NUM_BANKS-1:0]        w_en,
  output logic [NUM_BANKS*ADDR_W-1:0] w_addr_rd_flat,
  output logic                        done
);

  state_e              state_r, state_s;
  logic [ADDR_W-1:0]   cnt_r, cnt_s;      // lane 0 address, 0 whenever lane 0 is idle
  logic                en0_r, en0_s;      // lane 0 enable
  logic [ADDR_W-1:0]   end_r, end_s;      // captured last address
  logic [DRAIN_W-1:0]  drain_r, drain_s;
  logic                done_r, done_s;

  logic [NUM_BANKS-2:0]            dl_en_s;
  logic [(NUM_BANKS-1)*ADDR_W-1:0] dl_addr_s;

  // Next-state and next-value logic for the sweep FSM and its counters
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    en0_s   = en0_r;
    end_s   = end_r;
    drain_s = drain_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
          en0_s   = 1'b1;
          cnt_s   = addr_start;
          // An inverted range collapses to the single address addr_start
          end_s   = (addr_end < addr_start) ? addr_start : addr_end;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Terminate by compare so addr_end at the top of the range never wraps
        if (cnt_r == end_r) begin
          state_s = ST_DRAIN;
          en0_s   = 1'b0;
          cnt_s   = '0;
          drain_s = '0;
        end else begin
          cnt_s = cnt_r + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_r == DRAIN_LAST) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          drain_s = '0;
        end else begin
          drain_s = drain_r + DRAIN_W'(1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        en0_s   = 1'b0;
        cnt_s   = '0;
        drain_s = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      en0_r   <= 1'b0;
      end_r   <= '0;
      drain_r <= '0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      en0_r   <= en0_s;
      end_r   <= end_s;
      drain_r <= drain_s;
      done_r  <= done_s;
    end
  end

  weight_bram_controller_skew_delay_line u_skew (
    .clk       (clk),
    .rst       (rst),
    .en_in     (en0_r),
    .addr_in   (cnt_r),
    .en_taps   (dl_en_s),
    .addr_taps (dl_addr_s)
  );

  assign w_en           = {dl_en_s, en0_r};
  assign w_addr_rd_flat = {dl_addr_s, cnt_r};
  assign done           = done_r;

endmodule

// File: tb/tb_weight_bram_controller.sv
// Self-checking bench: directed and random sweeps compared every cycle against a
// wavefront model (bank i active while 1 <= cycles_since_start - i <= N).
module tb_weight_bram_controller;
  import weight_bram_controller_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        start;
  logic [ADDR_W-1:0]           addr_start;
  logic [ADDR_W-1:0]           addr_end;
  logic [NUM_BANKS-1:0]        w_en;
  logic [NUM_BANKS*ADDR_W-1:0] w_addr_rd_flat;
  logic                        done;

  int errors = 0;
  int checks = 0;

  // Reference model state: cycles elapsed since the accepted start edge
  bit m_active = 1'b0;
  int m_c = 0;
  int m_n = 0;
  int m_sa = 0;

  weight_bram_controller dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .addr_start     (addr_start),
    .addr_end       (addr_end),
    .w_en           (w_en),
    .w_addr_rd_flat (w_addr_rd_flat),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Advance one cycle and compare outputs against the model (sampled on the falling edge)
  task automatic step();
    logic [NUM_BANKS-1:0]        e_en;
    logic [NUM_BANKS*ADDR_W-1:0] e_addr;
    logic                        e_done;
    int                          d;
    @(negedge clk);
    if (m_active) m_c++;
    e_en   = '0;
    e_addr = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      d = m_c - i;
      if (m_active && d >= 1 && d <= m_n) begin
        e_en[i] = 1'b1;
        e_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(m_sa + d - 1);
      end
    end
    e_done = m_active && (m_c == m_n + NUM_BANKS);
    checks++;
    assert (w_en === e_en) else begin
      errors++;
      $error("FAIL w_en c=%0d got %h expected %h", m_c, w_en, e_en);
    end
    checks++;
    assert (w_addr_rd_flat === e_addr) else begin
      errors++;
      $error("FAIL w_addr c=%0d got %h expected %h", m_c, w_addr_rd_flat, e_addr);
    end
    checks++;
    assert (done === e_done) else begin
      errors++;
      $error("FAIL done c=%0d got %b expected %b", m_c, done, e_done);
    end
  endtask

  // Full sweep: optional ignored start mid-sweep (busy_at>0) and in the DONE cycle
  task automatic run_sweep(input int a, input int e, input int busy_at, input bit done_start);
    addr_start = ADDR_W'(a);
    addr_end   = ADDR_W'(e);
    start      = 1'b1;
    m_active   = 1'b1;
    m_c        = 0;
    m_sa       = a;
    m_n        = (e >= a) ? (e - a + 1) : 1;
    step();
    start      = 1'b0;
    addr_start = ADDR_W'($urandom);
    addr_end   = ADDR_W'($urandom);
    while (m_c < m_n + NUM_BANKS) begin
      start = (m_c == busy_at);
      if (start) begin
        addr_start = ADDR_W'($urandom);
        addr_end   = ADDR_W'($urandom);
      end
      step();
    end
    start    = done_start;
    m_active = 1'b0;
    step();
    start    = 1'b0;
  endtask

  initial begin
    int a;
    int e;
    rst        = 1'b1;
    start      = 1'b1;
    addr_start = ADDR_W'($urandom);
    addr_end   = ADDR_W'($urandom);
    step();
    step();
    rst   = 1'b0;
    start = 1'b0;
    step();

    // Basic sweep with an ignored start mid-run
    run_sweep(128, 255, 40, 1'b0);
    // Single address, plus a start in the DONE cycle that must be ignored
    run_sweep(5, 5, 0, 1'b1);
    step();
    // Inverted range behaves as one address
    run_sweep(200, 100, 3, 1'b0);

    // Reset during RUN aborts the sweep with no done
    addr_start = ADDR_W'(10);
    addr_end   = ADDR_W'(60);
    start      = 1'b1;
    m_active   = 1'b1;
    m_c        = 0;
    m_sa       = 10;
    m_n        = 51;
    step();
    start = 1'b0;
    repeat (20) step();
    rst      = 1'b1;
    m_active = 1'b0;
    step();
    rst = 1'b0;
    repeat (70) step();

    // Clean sweep after reset, then back-to-back start right after done
    run_sweep(300, 310, 0, 1'b0);
    run_sweep(0, 3, 0, 1'b0);
    // Top of address range terminates by compare
    run_sweep(505, 511, 2, 1'b0);

    // Random ranges, some inverted
    repeat (6) begin
      a = int'($urandom_range(0, 511));
      if ($urandom_range(0, 3) == 0) begin
        e = int'($urandom_range(0, 511));
      end else begin
        e = a + int'($urandom_range(0, 24));
        if (e > 511) e = 511;
      end
      run_sweep(a, e, int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
      repeat (int'($urandom_range(0, 3))) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
